// File: rtl/sfx_pkg.sv
// Shared types and helpers for the sound-effect voice mixer.
package sfx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACCUM,
      OUTPUT,
      ADVANCE
   } state_t;

   localparam int ATTEN_W = 4;

   // Accumulator width: one sample plus headroom for N voices plus a guard bit.
   function automatic int acc_width(input int n, input int sample_w);
      return sample_w + $clog2(n) + 1;
   endfunction

   // Clamp a wide signed value into the signed range of sample_w bits.
   function automatic logic signed [63:0] sat_sample(input logic signed [63:0] acc,
                                                     input int sample_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (sample_w - 1));
      if (acc > hi)
         return hi;
      else if (acc < lo)
         return lo;
      else
         return acc;
   endfunction

endpackage

// File: rtl/sfx_voice_ctrl.sv
// Per-voice playback control: pending trigger/stop latches, active flag and
// ROM address counter. State only moves in the ADVANCE slot so a sample read
// in progress always sees a stable address.
module sfx_voice_ctrl
   import sfx_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trig,
   input  logic              stop,
   input  logic              loop,
   input  logic [ADDR_W-1:0] len,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic              active
);

   logic pend_trig;
   logic pend_stop;

   // Collect control pulses and apply them, plus address stepping, in ADVANCE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_trig <= 1'b0;
         pend_stop <= 1'b0;
         active    <= 1'b0;
         addr      <= '0;
      end else if (advance) begin
         // Pulses arriving in the ADVANCE cycle itself are kept for next time.
         pend_trig <= trig;
         pend_stop <= stop;
         if (pend_trig) begin
            active <= 1'b1;
            addr   <= '0;
         end else if (pend_stop) begin
            active <= 1'b0;
            addr   <= '0;
         end else if (active && addr == len) begin
            active <= loop;
            addr   <= '0;
         end else if (active) begin
            addr <= addr + 1'b1;
         end
      end else begin
         pend_trig <= pend_trig | trig;
         pend_stop <= pend_stop | stop;
      end
   end

endmodule

// File: rtl/sfx_voice_mixer.sv
// N-voice sound-effect mixer: on each codec request, reads one sample per
// voice, accumulates the attenuated active voices, saturates and presents
// one mono sample, then advances every voice's address.
module sfx_voice_mixer
   import sfx_pkg::*;
#(
   parameter int N_VOICES = 4,
   parameter int SAMPLE_W = 16,
   parameter int ADDR_W   = 16,
   parameter int ROM_LAT  = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sample_req,
   input  logic [N_VOICES-1:0]          voice_trig,
   input  logic [N_VOICES-1:0]          voice_stop,
   input  logic [N_VOICES-1:0]          voice_loop,
   input  logic [ATTEN_W*N_VOICES-1:0]  voice_atten,
   input  logic [ADDR_W*N_VOICES-1:0]   voice_len,
   input  logic                         mute,
   output logic [ADDR_W*N_VOICES-1:0]   rom_addr,
   input  logic [SAMPLE_W*N_VOICES-1:0] rom_data,
   output logic [SAMPLE_W-1:0]          audio_sample,
   output logic                         sample_valid,
   output logic [N_VOICES-1:0]          voice_active,
   output logic                         overrun,
   input  logic                         clr_overrun
);

   localparam int ACC_W = acc_width(N_VOICES, SAMPLE_W);
   localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

   state_t                     state;
   logic [1:0]                 cnt;
   logic [IDX_W-1:0]           idx;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [ACC_W-1:0]    contrib;
   logic signed [SAMPLE_W-1:0] shifted;
   logic signed [63:0]         sat_wide;
   logic                       last_voice;
   logic signed [SAMPLE_W-1:0] voice_data [N_VOICES];
   logic [ATTEN_W-1:0]         atten      [N_VOICES];

   for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
      assign voice_data[v] = rom_data[v*SAMPLE_W +: SAMPLE_W];
      assign atten[v]      = voice_atten[v*ATTEN_W +: ATTEN_W];

      sfx_voice_ctrl #(
         .ADDR_W(ADDR_W)
      ) u_ctrl (
         .clk     (clk),
         .reset   (reset),
         .trig    (voice_trig[v]),
         .stop    (voice_stop[v]),
         .loop    (voice_loop[v]),
         .len     (voice_len[v*ADDR_W +: ADDR_W]),
         .advance (state == ADVANCE),
         .addr    (rom_addr[v*ADDR_W +: ADDR_W]),
         .active  (voice_active[v])
      );
   end

   // Contribution of the voice selected by idx and the saturated running sum.
   always_comb begin
      shifted = voice_data[idx] >>> atten[idx];
      contrib = '0;
      if (voice_active[idx])
         contrib = {{(ACC_W-SAMPLE_W){shifted[SAMPLE_W-1]}}, shifted};
      acc_next   = acc + contrib;
      sat_wide   = sat_sample({{(64-ACC_W){acc_next[ACC_W-1]}}, acc_next}, SAMPLE_W);
      last_voice = (idx == IDX_W'(N_VOICES - 1));
   end

   // Sequencer: wait for ROM data, accumulate one voice per cycle, publish, advance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         acc          <= '0;
         audio_sample <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (sample_req && state != IDLE)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (sample_req) begin
                  state <= WAIT;
                  cnt   <= 2'(ROM_LAT - 1);
               end
            end
            WAIT: begin
               if (cnt == 2'd0) begin
                  state <= ACCUM;
                  idx   <= '0;
                  acc   <= '0;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               if (last_voice) begin
                  // Output register loads on entry so it is valid throughout OUTPUT.
                  state        <= OUTPUT;
                  audio_sample <= mute ? '0 : sat_wide[SAMPLE_W-1:0];
                  sample_valid <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            OUTPUT:  state <= ADVANCE;
            ADVANCE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfx_voice_mixer.sv
// Self-checking bench for sfx_voice_mixer with a transaction-level voice model.
module tb_sfx_voice_mixer;

   localparam int NV = 4;
   localparam int SW = 16;
   localparam int AW = 16;
   localparam int RL = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b0;
   logic              sample_req = 1'b0;
   logic [NV-1:0]     voice_trig = '0;
   logic [NV-1:0]     voice_stop = '0;
   logic [NV-1:0]     voice_loop = '0;
   logic [4*NV-1:0]   voice_atten = '0;
   logic [AW*NV-1:0]  voice_len = '0;
   logic              mute = 1'b0;
   logic [AW*NV-1:0]  rom_addr;
   logic [SW*NV-1:0]  rom_data;
   logic [SW-1:0]     audio_sample;
   logic              sample_valid;
   logic [NV-1:0]     voice_active;
   logic              overrun;
   logic              clr_overrun = 1'b0;

   sfx_voice_mixer #(.N_VOICES(NV), .SAMPLE_W(SW), .ADDR_W(AW), .ROM_LAT(RL)) dut (
      .clk(clk), .reset(reset), .sample_req(sample_req), .voice_trig(voice_trig),
      .voice_stop(voice_stop), .voice_loop(voice_loop), .voice_atten(voice_atten),
      .voice_len(voice_len), .mute(mute), .rom_addr(rom_addr), .rom_data(rom_data),
      .audio_sample(audio_sample), .sample_valid(sample_valid),
      .voice_active(voice_active), .overrun(overrun), .clr_overrun(clr_overrun)
   );

   // Second instance with a slower ROM and fewer voices for the latency rule.
   logic        l_req = 1'b0;
   logic [1:0]  l_trig = '0;
   logic [31:0] l_addr;
   logic [15:0] l_sample;
   logic        l_valid;
   logic [1:0]  l_active;
   logic        l_overrun;

   sfx_voice_mixer #(.N_VOICES(2), .SAMPLE_W(16), .ADDR_W(16), .ROM_LAT(3)) dut_lat (
      .clk(clk), .reset(reset), .sample_req(l_req), .voice_trig(l_trig),
      .voice_stop(2'b00), .voice_loop(2'b11), .voice_atten(8'h00),
      .voice_len(32'h0), .mute(1'b0), .rom_addr(l_addr), .rom_data(32'h0123_0123),
      .audio_sample(l_sample), .sample_valid(l_valid),
      .voice_active(l_active), .overrun(l_overrun), .clr_overrun(1'b0)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ROM contents: 0 = addr*100, 1 = constant, 2 = scrambled pattern
   int          rom_mode  [NV];
   logic [15:0] rom_const [NV];
   logic [15:0] rom_q     [NV];

   // Reference state
   bit          m_active [NV];
   logic [15:0] m_addr   [NV];
   bit          m_pt     [NV];
   bit          m_ps     [NV];
   bit          m_ovr;

   function automatic logic [15:0] rom_word(input int v, input logic [15:0] a);
      case (rom_mode[v])
         0:       return 16'(a * 100);
         1:       return rom_const[v];
         default: return 16'(a * 16'd40503) ^ 16'((v + 1) * 23131);
      endcase
   endfunction

   always @(posedge clk)
      for (int v = 0; v < NV; v++) rom_q[v] <= rom_word(v, rom_addr[v*AW +: AW]);

   for (genvar g = 0; g < NV; g++) begin : g_rom
      assign rom_data[g*SW +: SW] = rom_q[g];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model_expect();
      int sum;
      int s;
      sum = 0;
      for (int v = 0; v < NV; v++) begin
         if (m_active[v]) begin
            s = int'($signed(rom_word(v, m_addr[v])));
            sum += s >>> int'(voice_atten[v*4 +: 4]);
         end
      end
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      return mute ? 16'h0 : 16'(sum);
   endfunction

   function automatic void model_advance();
      for (int v = 0; v < NV; v++) begin
         if (m_pt[v]) begin
            m_active[v] = 1'b1; m_addr[v] = '0;
         end else if (m_ps[v]) begin
            m_active[v] = 1'b0; m_addr[v] = '0;
         end else if (m_active[v] && m_addr[v] == voice_len[v*AW +: AW]) begin
            m_active[v] = voice_loop[v]; m_addr[v] = '0;
         end else if (m_active[v]) begin
            m_addr[v] = m_addr[v] + 16'd1;
         end
         m_pt[v] = 1'b0;
         m_ps[v] = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < NV; v++) begin
         m_active[v] = 0; m_addr[v] = '0; m_pt[v] = 0; m_ps[v] = 0;
      end
      m_ovr = 0;
   endfunction

   function automatic logic [NV-1:0] m_act_vec();
      logic [NV-1:0] r;
      for (int v = 0; v < NV; v++) r[v] = m_active[v];
      return r;
   endfunction

   function automatic logic [AW*NV-1:0] m_addr_vec();
      logic [AW*NV-1:0] r;
      for (int v = 0; v < NV; v++) r[v*AW +: AW] = m_addr[v];
      return r;
   endfunction

   task automatic pulse_ctrl(input logic [NV-1:0] mt, input logic [NV-1:0] ms);
      voice_trig = mt;
      voice_stop = ms;
      tick();
      voice_trig = '0;
      voice_stop = '0;
      for (int v = 0; v < NV; v++) begin
         if (mt[v]) m_pt[v] = 1'b1;
         if (ms[v]) m_ps[v] = 1'b1;
      end
   endtask

   // One full request; mt/ms pulse during WAIT, extra issues a second request mid-read.
   task automatic do_sample(input logic [NV-1:0] mt, input logic [NV-1:0] ms, input bit extra);
      logic [15:0] exp;
      int lat;
      exp = model_expect();
      sample_req = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         sample_req = extra && (lat == 2);
         voice_trig = (lat == 1) ? mt : '0;
         voice_stop = (lat == 1) ? ms : '0;
      end while (!sample_valid && lat < 40);
      sample_req = 1'b0;
      voice_trig = '0;
      voice_stop = '0;
      chk("latency", lat, RL + NV + 1);
      chk("sample", audio_sample, exp);
      for (int v = 0; v < NV; v++) begin
         if (mt[v]) m_pt[v] = 1'b1;
         if (ms[v]) m_ps[v] = 1'b1;
      end
      if (extra) m_ovr = 1'b1;
      tick();
      chk("valid_pulse", sample_valid, 1'b0);
      tick();
      model_advance();
      chk("hold", audio_sample, exp);
      chk("active", voice_active, m_act_vec());
      chk("addr", rom_addr, m_addr_vec());
      chk("overrun", overrun, m_ovr);
   endtask

   task automatic clear_overrun();
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      m_ovr = 1'b0;
      chk("overrun_clr", overrun, 1'b0);
   endtask

   task automatic lreq(output int lat);
      l_req = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         l_req = 1'b0;
      end while (!l_valid && lat < 40);
      tick();
      tick();
   endtask

   function automatic void set_voice(input int v, input int mode, input logic [15:0] cval,
                                     input logic [15:0] len, input bit lp, input logic [3:0] at);
      rom_mode[v]  = mode;
      rom_const[v] = cval;
      voice_len[v*AW +: AW] = len;
      voice_loop[v] = lp;
      voice_atten[v*4 +: 4] = at;
   endfunction

   initial begin
      int lat;
      for (int v = 0; v < NV; v++) set_voice(v, 0, 16'h0, 16'd0, 1'b0, 4'd0);
      model_reset();
      repeat (3) tick();
      chk("rst_sample", audio_sample, 16'h0);
      chk("rst_valid", sample_valid, 1'b0);
      chk("rst_active", voice_active, '0);
      chk("rst_addr", rom_addr, '0);
      chk("rst_overrun", overrun, 1'b0);
      reset = 1'b1;
      tick();

      // Latency with ROM_LAT=3, two voices
      l_trig = 2'b01;
      tick();
      l_trig = 2'b00;
      lreq(lat);
      chk("lat3_first", l_sample, 16'h0);
      lreq(lat);
      chk("lat3_latency", lat, 6);
      chk("lat3_sample", l_sample, 16'h0123);
      chk("lat3_overrun", l_overrun, 1'b0);

      // One-shot ramp on voice 0
      set_voice(0, 0, 16'h0, 16'd3, 1'b0, 4'd0);
      pulse_ctrl(4'b0001, 4'b0000);
      repeat (6) do_sample('0, '0, 0);

      // Looping ramp on voice 0
      voice_loop[0] = 1'b1;
      pulse_ctrl(4'b0001, 4'b0000);
      repeat (11) do_sample('0, '0, 0);

      // Saturation, both polarities, then attenuation
      for (int v = 0; v < NV; v++) set_voice(v, 1, 16'h7000, 16'd50, 1'b1, 4'd0);
      pulse_ctrl(4'b1111, 4'b0000);
      repeat (2) do_sample('0, '0, 0);
      chk("sat_pos", audio_sample, 16'h7FFF);
      for (int v = 0; v < NV; v++) rom_const[v] = 16'h9000;
      do_sample('0, '0, 0);
      chk("sat_neg", audio_sample, 16'h8000);
      set_voice(1, 1, 16'h1000, 16'd50, 1'b1, 4'd4);
      pulse_ctrl(4'b0010, 4'b1101);
      repeat (2) do_sample('0, '0, 0);
      chk("atten", audio_sample, 16'h0100);

      // Trigger and stop together mid-read, plus an overrunning request
      set_voice(2, 2, 16'h0, 16'd5, 1'b1, 4'd1);
      do_sample(4'b0100, 4'b0100, 1);
      chk("trig_wins", voice_active[2], 1'b1);
      clear_overrun();
      do_sample('0, '0, 0);

      // Mute keeps the voices advancing
      mute = 1'b1;
      repeat (2) do_sample('0, '0, 0);
      mute = 1'b0;

      // Asynchronous reset in the middle of accumulation
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_sample", audio_sample, 16'h0);
      chk("mid_rst_valid", sample_valid, 1'b0);
      chk("mid_rst_active", voice_active, '0);
      chk("mid_rst_addr", rom_addr, '0);
      chk("mid_rst_overrun", overrun, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      model_reset();
      tick();
      do_sample('0, '0, 0);
      chk("post_rst_sample", audio_sample, 16'h0);

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         logic [NV-1:0] rt, rs, mt, ms;
         bit extra;
         if (it % 8 == 0) begin
            for (int v = 0; v < NV; v++)
               set_voice(v, int'($urandom_range(0, 2)), 16'($urandom),
                         16'($urandom_range(0, 4)), 1'($urandom),
                         ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0);
         end
         rt = NV'($urandom) & NV'($urandom);
         rs = NV'($urandom) & NV'($urandom) & NV'($urandom);
         if (rt != '0 || rs != '0) pulse_ctrl(rt, rs);
         mute = ($urandom_range(0, 7) == 0);
         extra = ($urandom_range(0, 9) == 0);
         mt = ($urandom_range(0, 4) == 0) ? NV'($urandom) : '0;
         ms = ($urandom_range(0, 4) == 0) ? NV'($urandom) : '0;
         do_sample(mt, ms, extra);
         if (m_ovr) clear_overrun();
      end
      mute = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
